// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared definitions for the datapath instruction sequencer.
//   - instruction class codes and field bit positions
//   - FSM state enum
//   - decoded-control struct produced by dp_seq_decode
package dp_seq_pkg;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LOADI = 2'b01;
    localparam logic [1:0] CLS_SETZ  = 2'b10;
    localparam logic [1:0] CLS_HALT  = 2'b11;

    // Field LSB positions within a 32-bit instruction word
    localparam int unsigned CLS_LSB   = 30;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned FORM_BIT  = 26;
    localparam int unsigned VEC_LSB   = 24;
    localparam int unsigned A_LSB     = 20;
    localparam int unsigned B_LSB     = 16;
    localparam int unsigned C_LSB     = 12;
    localparam int unsigned D_LSB     = 8;
    localparam int unsigned Y1_LSB    = 4;
    localparam int unsigned Y2_LSB    = 0;
    localparam int unsigned TGT_LSB   = 26;
    localparam int unsigned ZMASK_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFetchImm,
        StIssue,
        StHalted
    } state_e;

    typedef struct packed {
        logic [1:0] cls;
        logic [2:0] op;
        logic       form;
        logic [1:0] vec;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] y1;
        logic [3:0] y2;
        logic [1:0] write;
        logic [3:0] target;
        logic [3:0] zmask;
    } ctrl_t;

endpackage

// File: rtl/dp_seq_decode.sv
// dp_seq_decode: combinational instruction decoder.
//   instr in 32 : instruction word
//   ctrl  out   : decoded controls; ALU fields are zero for non-ALU classes,
//                 target/zmask are always extracted for LOADI/SETZ use.
module dp_seq_decode
    import dp_seq_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.cls    = instr[CLS_LSB +: 2];
        ctrl.target = instr[TGT_LSB +: 4];
        ctrl.zmask  = instr[ZMASK_LSB +: 4];
        if (ctrl.cls == CLS_ALU) begin
            ctrl.op    = instr[OP_LSB +: 3];
            ctrl.form  = instr[FORM_BIT];
            ctrl.vec   = instr[VEC_LSB +: 2];
            ctrl.a     = instr[A_LSB +: 4];
            ctrl.b     = instr[B_LSB +: 4];
            ctrl.c     = instr[C_LSB +: 4];
            ctrl.d     = instr[D_LSB +: 4];
            ctrl.y1    = instr[Y1_LSB +: 4];
            ctrl.y2    = instr[Y2_LSB +: 4];
            // Register 0 as a destination means "no write"
            ctrl.write = {ctrl.y2 != 4'd0, ctrl.y1 != 4'd0};
        end
    end

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: fetches instructions over a req/valid handshake and issues one
// cycle of registered datapath controls per instruction.
//   clk, rst_n         : clock, async active-low reset
//   start              : begin execution at RESET_PC (from IDLE/HALTED only)
//   imem_req/addr      : fetch request and address (addr = pc)
//   imem_valid/data    : fetch response
//   op..Y2, write,
//   const_a, constant,
//   zero_reg           : registered datapath controls
//   busy, halted       : status
module dp_sequencer
    import dp_seq_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [3:0]         ZERO_RESET = 4'b1110
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_data,
    output logic [2:0]        op,
    output logic              form,
    output logic [1:0]        vec,
    output logic [3:0]        A,
    output logic [3:0]        B,
    output logic [3:0]        C,
    output logic [3:0]        D,
    output logic [3:0]        Y1,
    output logic [3:0]        Y2,
    output logic [1:0]        write,
    output logic              const_a,
    output logic [31:0]       constant,
    output logic [3:0]        zero_reg,
    output logic              busy,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q;
    logic [31:0]       dec_word;
    ctrl_t             dec;
    logic              fetch_acc, imm_acc;

    logic [2:0]  op_q;
    logic        form_q;
    logic [1:0]  vec_q;
    logic [3:0]  a_q, b_q, c_q, d_q, y1_q, y2_q;
    logic [1:0]  write_q;
    logic        const_a_q;
    logic [31:0] constant_q;
    logic [3:0]  zero_q;

    // In FETCH decode the incoming word; in FETCH_IMM the held LOADI word
    assign dec_word  = (state_q == StFetch) ? imem_data : ir_q;
    assign fetch_acc = (state_q == StFetch) && imem_valid;
    assign imm_acc   = (state_q == StFetchImm) && imem_valid;

    dp_seq_decode u_decode (
        .instr (dec_word),
        .ctrl  (dec)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetch_acc) ir_q <= imem_data;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = RESET_PC;
                end
            end
            StFetch: begin
                if (imem_valid) begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (dec.cls == CLS_LOADI)     state_d = StFetchImm;
                    else if (dec.cls == CLS_HALT) state_d = StHalted;
                    else                          state_d = StIssue;
                end
            end
            StFetchImm: begin
                if (imem_valid) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs
    always_comb begin
        imem_req  = (state_q == StFetch) || (state_q == StFetchImm);
        imem_addr = pc_q;
        busy      = (state_q != StIdle) && (state_q != StHalted);
        halted    = (state_q == StHalted);
    end

    // Datapath output registers, loaded on the edge entering ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            form_q     <= 1'b0;
            vec_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            write_q    <= '0;
            const_a_q  <= 1'b0;
            constant_q <= '0;
            zero_q     <= ZERO_RESET;
        end else begin
            // Write strobes last exactly one cycle
            write_q   <= 2'b00;
            const_a_q <= 1'b0;
            if (fetch_acc && dec.cls == CLS_ALU) begin
                op_q    <= dec.op;
                form_q  <= dec.form;
                vec_q   <= dec.vec;
                a_q     <= dec.a;
                b_q     <= dec.b;
                c_q     <= dec.c;
                d_q     <= dec.d;
                y1_q    <= dec.y1;
                y2_q    <= dec.y2;
                write_q <= dec.write;
            end else if (fetch_acc && dec.cls == CLS_SETZ) begin
                zero_q <= dec.zmask;
            end else if (imm_acc) begin
                op_q       <= '0;
                form_q     <= 1'b0;
                vec_q      <= '0;
                a_q        <= '0;
                b_q        <= '0;
                c_q        <= '0;
                d_q        <= '0;
                y1_q       <= dec.target;
                y2_q       <= '0;
                write_q    <= 2'b01;
                const_a_q  <= 1'b1;
                constant_q <= imem_data;
            end
        end
    end

    assign op       = op_q;
    assign form     = form_q;
    assign vec      = vec_q;
    assign A        = a_q;
    assign B        = b_q;
    assign C        = c_q;
    assign D        = d_q;
    assign Y1       = y1_q;
    assign Y2       = y2_q;
    assign write    = write_q;
    assign const_a  = const_a_q;
    assign constant = constant_q;
    assign zero_reg = zero_q;

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Instruction sequencer that drives the `datapath` control inputs. It fetches 32-bit instruction words from an instruction memory over a request/valid handshake and decodes each word into one cycle of datapath controls: op, form, vec, register selects, write enables, constant injection and zero-register mask. It is the control side of the datapath's control interface, replacing hand-driven stimulus with a program.

## Interface
- `ADDR_W`, 8: instruction address width.
- `RESET_PC`, 0: first fetch address after `start`.
- `ZERO_RESET`, 4'b1110: reset value of the `zero_reg` output.
- `clk` in 1: clock. One clock domain; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse. Begins execution at `RESET_PC`. Ignored unless the FSM is in IDLE or HALTED.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address. Stable while `imem_req` is high.
- `imem_valid` in 1: `imem_data` is valid. Accepted only while `imem_req` is high.
- `imem_data` in 32: instruction or immediate word.
- `op` out 3, `form` out 1, `vec` out 2: ALU controls.
- `A`, `B`, `C`, `D` out 4 each: source register selects.
- `Y1`, `Y2` out 4 each: destination selects.
- `write` out 2: write enables, {Y2, Y1}.
- `const_a` out 1: inject `constant` on operand A.
- `constant` out 32: immediate value.
- `zero_reg` out 4: zero-register mask.
- `busy` out 1: high in any state except IDLE and HALTED.
- `halted` out 1: high in HALTED.

## Operation
- Encoding: bits [31:30] hold the instruction class.
- Class 00, ALU:
  - Fields: [29:27] op, [26] form, [25:24] vec, [23:20] A, [19:16] B, [15:12] C, [11:8] D, [7:4] Y1, [3:0] Y2.
  - `write` = {Y2≠0, Y1≠0}; `const_a` = 0.
- Class 01, LOADI:
  - [29:26] is the target register. The next word in memory is the 32-bit immediate.
  - Issue: Y1 = target, Y2 = 0, `write` = 01, `const_a` = 1, `constant` = immediate. All other selects and ALU controls are 0.
- Class 10, SETZ: `zero_reg` ← [3:0]. The value holds until the next SETZ or reset. Issues no write.
- Class 11, HALT: enter HALTED.
- FSM states: IDLE, FETCH, FETCH_IMM, ISSUE, HALTED.
- Transitions:
  - IDLE / HALTED → FETCH on `start`; pc ← `RESET_PC`.
  - FETCH, on `imem_valid`: instruction register ← data, pc ← pc+1.
    - LOADI → FETCH_IMM.
    - HALT → HALTED.
    - Otherwise → ISSUE.
  - FETCH_IMM, on `imem_valid`: `constant` ← data, pc ← pc+1, → ISSUE.
  - ISSUE → FETCH, always after one cycle.
- `imem_req` is high in FETCH and FETCH_IMM. `imem_addr` = pc.
- pc is ADDR_W bits and wraps from 2^ADDR_W−1 to 0 without error. An immediate word at address 0 after a wrap is legal.
- The pc increment on HALT is retained in pc but is unused, since restart reloads `RESET_PC`.
- All datapath outputs are registered.
  - `write` and `const_a` are nonzero only in the ISSUE cycle.
  - op, form, vec, A, B, C, D, Y1, Y2 and `constant` hold their last issued values between issues.

## Timing
- Reset values:
  - State IDLE, pc = `RESET_PC`, `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - All datapath outputs 0, except `zero_reg` = `ZERO_RESET`.
  - `busy` = 0, `halted` = 0.
- `imem_valid` may arrive in the same cycle as `imem_req` rises (zero wait) or any number of cycles later.
- The request holds until valid. `imem_valid` outside FETCH/FETCH_IMM is ignored.
- Latency, `start` edge to first ISSUE cycle:
  - ALU: 2 cycles, with zero-wait memory.
  - LOADI: 3 cycles.
- Throughput: ALU instructions issue every 2 cycles; LOADI every 3 cycles.
- SETZ passes through ISSUE with `write` = 00. `zero_reg` updates on the edge entering ISSUE.
- `start` while busy is ignored.
- Reset asserted mid-fetch or mid-issue clears everything immediately and asynchronously. The write in flight is dropped; `write` goes to 00 without waiting for a clock.

## Structure
- Package `dp_seq_pkg` holds:
  - Class constants CLS_ALU, CLS_LOADI, CLS_SETZ, CLS_HALT.
  - Field bit-position constants.
  - The FSM state enum.
  - A decoded-control struct type.
- One sub-module, `dp_seq_decode`: purely combinational, instruction word → control struct. The FSM, pc and output registers stay in the top.

## Test plan
- Reset then `start`, with memory [0] = LOADI r1, [1] = 5, [2] = HALT, zero-wait:
  - ISSUE 3 cycles after `start`, with Y1 = 1, `write` = 01, `const_a` = 1, `constant` = 5.
  - Then `halted` = 1, `busy` = 0.
- ALU word: op = 3, form = 1, vec = 2, A = 1, C = 2, Y1 = 3, Y2 = 0 → one ISSUE cycle with those fields, `write` = 01, `const_a` = 0. `write` = 00 in the adjacent cycles.
- SETZ 4'b1010, then ALU → `zero_reg` = 1010 from the SETZ ISSUE cycle onward. No write occurs on SETZ.
- `imem_valid` delayed 3 cycles on the immediate fetch:
  - `imem_req` and `imem_addr` stay stable throughout.
  - `constant` is captured only on the valid cycle.
  - A spurious `imem_valid` pulse while in ISSUE is ignored.
- `ADDR_W` = 2, program LOADI at address 3 with its immediate at address 0 → immediate fetched from `imem_addr` 0 and issued correctly.
- `rst_n` dropped during FETCH_IMM:
  - Outputs immediately return to reset values, with `zero_reg` = 1110.
  - After a new `start`, execution restarts at `RESET_PC`.
